// File: rtl/alu_reservation_station_pkg.sv
// rtl/alu_reservation_station_pkg.sv - shared widths, instruction types and RS entry layout
package alu_reservation_station_pkg;

  localparam int DEF_TYPE_W  = 6;
  localparam int DEF_XLEN    = 32;
  localparam int DEF_TAG_W   = 4;
  localparam int DEF_RS_SIZE = 8;

  typedef enum logic [DEF_TYPE_W-1:0] {
    ITYPE_ADD  = 6'd1,
    ITYPE_SUB  = 6'd2,
    ITYPE_ADDI = 6'd3,
    ITYPE_BEQ  = 6'd8,
    ITYPE_BNE  = 6'd9,
    ITYPE_JAL  = 6'd16,
    ITYPE_JALR = 6'd17
  } rs_itype_e;

  // Entry layout at default widths, shared with the load/store buffer.
  typedef struct packed {
    logic                  busy;
    logic [DEF_TYPE_W-1:0] itype;
    logic [DEF_XLEN-1:0]   vj;
    logic [DEF_XLEN-1:0]   vk;
    logic [DEF_TAG_W-1:0]  qj;
    logic [DEF_TAG_W-1:0]  qk;
    logic                  qj_rdy;
    logic                  qk_rdy;
    logic [DEF_XLEN-1:0]   a;
    logic [DEF_XLEN-1:0]   pc;
    logic [DEF_TAG_W-1:0]  dest;
  } rs_entry_t;

endpackage

// File: rtl/alu_reservation_station_if.sv
// rtl/alu_reservation_station_if.sv - issue, CDB and dispatch buses of the ALU reservation station
// master: decode/issue + CDB + execute side; slave: the reservation station.
interface alu_reservation_station_if
  import alu_reservation_station_pkg::*;
#(
  parameter int TYPE_W = DEF_TYPE_W,
  parameter int XLEN   = DEF_XLEN,
  parameter int TAG_W  = DEF_TAG_W
);
  logic              iss_valid_in;
  logic [TYPE_W-1:0] iss_type_in;
  logic [XLEN-1:0]   iss_vj_in;
  logic [XLEN-1:0]   iss_vk_in;
  logic              iss_qj_rdy_in;
  logic              iss_qk_rdy_in;
  logic [TAG_W-1:0]  iss_qj_in;
  logic [TAG_W-1:0]  iss_qk_in;
  logic [XLEN-1:0]   iss_a_in;
  logic [XLEN-1:0]   iss_pc_in;
  logic [TAG_W-1:0]  iss_dest_in;
  logic              full_out;

  logic              cdb_valid_in;
  logic [TAG_W-1:0]  cdb_tag_in;
  logic [XLEN-1:0]   cdb_value_in;

  logic              ex_valid_out;
  logic [TYPE_W-1:0] ex_type_out;
  logic [XLEN-1:0]   ex_vj_out;
  logic [XLEN-1:0]   ex_vk_out;
  logic [XLEN-1:0]   ex_a_out;
  logic [XLEN-1:0]   ex_pc_out;
  logic [TAG_W-1:0]  ex_dest_out;

  modport master (
    output iss_valid_in, iss_type_in, iss_vj_in, iss_vk_in, iss_qj_rdy_in, iss_qk_rdy_in,
           iss_qj_in, iss_qk_in, iss_a_in, iss_pc_in, iss_dest_in,
           cdb_valid_in, cdb_tag_in, cdb_value_in,
    input  full_out, ex_valid_out, ex_type_out, ex_vj_out, ex_vk_out, ex_a_out, ex_pc_out,
           ex_dest_out
  );

  modport slave (
    input  iss_valid_in, iss_type_in, iss_vj_in, iss_vk_in, iss_qj_rdy_in, iss_qk_rdy_in,
           iss_qj_in, iss_qk_in, iss_a_in, iss_pc_in, iss_dest_in,
           cdb_valid_in, cdb_tag_in, cdb_value_in,
    output full_out, ex_valid_out, ex_type_out, ex_vj_out, ex_vk_out, ex_a_out, ex_pc_out,
           ex_dest_out
  );
endinterface

// File: rtl/alu_reservation_station_rs_pick_ready.sv
// rtl/alu_reservation_station_rs_pick_ready.sv - combinational priority selector over a request vector
// Macro RS_AGE_SELECT_EN: pick the oldest request by wrap-aware age stamp instead of lowest index.
// Ports: age_i (macro only) per-entry age stamps, req_i request vector, valid_o any request, idx_o winner.
module rs_pick_ready #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
`ifdef RS_AGE_SELECT_EN
  input  logic [N-1:0][$clog2(N):0] age_i,
`endif
  input  logic [N-1:0]              req_i,
  output logic                      valid_o,
  output logic [IDX_W-1:0]          idx_o
);

`ifdef RS_AGE_SELECT_EN
  localparam int AGE_W = $clog2(N) + 1;

  // Live stamps are fewer than N issues apart, so a negative difference means a is older.
  function automatic logic older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
    logic [AGE_W-1:0] diff;
    diff = a - b;
    return diff[AGE_W-1];
  endfunction
`endif

  logic             found;
  logic [IDX_W-1:0] sel;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
`ifdef RS_AGE_SELECT_EN
      if (req_i[i] && (!found || older(age_i[i], age_i[sel]))) begin
`else
      if (req_i[i] && !found) begin
`endif
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end
  end

  assign valid_o = found;
  assign idx_o   = sel;

endmodule

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - Tomasulo reservation station for ALU/branch/jump instructions
// Macro RS_AGE_SELECT_EN: oldest-ready dispatch using per-entry age stamps.
// Ports: clk_in clock, rst_n_in sync active-low reset, rdy_in global ready (low freezes state),
//        clear_in mispredict flush, bus slave side of alu_reservation_station_if
//        (issue request/full, CDB snoop, registered dispatch to the execute unit).
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int RS_SIZE = DEF_RS_SIZE,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int TYPE_W  = DEF_TYPE_W,
  parameter int XLEN    = DEF_XLEN
) (
  input logic                      clk_in,
  input logic                      rst_n_in,
  input logic                      rdy_in,
  input logic                      clear_in,
  alu_reservation_station_if.slave bus
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic              busy;
    logic [TYPE_W-1:0] itype;
    logic [XLEN-1:0]   vj;
    logic [XLEN-1:0]   vk;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
    logic              qj_rdy;
    logic              qk_rdy;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   pc;
    logic [TAG_W-1:0]  dest;
  } entry_t;

  typedef struct packed {
    logic [TYPE_W-1:0] itype;
    logic [XLEN-1:0]   vj;
    logic [XLEN-1:0]   vk;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   pc;
    logic [TAG_W-1:0]  dest;
  } ex_t;

  entry_t           ent_q [RS_SIZE];
  entry_t           ent_d [RS_SIZE];
  entry_t           new_ent;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             ex_valid_q, ex_valid_d;
  ex_t              ex_q, ex_d;

  logic [RS_SIZE-1:0] ready_vec, free_vec;
  logic               disp_valid, free_valid, issue_acc;
  logic [IDX_W-1:0]   disp_idx, free_idx;
  logic               byp_j, byp_k;

`ifdef RS_AGE_SELECT_EN
  logic [RS_SIZE-1:0][IDX_W:0] age_q, age_d;
  logic [IDX_W:0]              age_cnt_q, age_cnt_d;
`endif

  // Readiness is taken from registered state only, so a snoop never dispatches in its own cycle.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = ent_q[i].busy & ent_q[i].qj_rdy & ent_q[i].qk_rdy;
      free_vec[i]  = ~ent_q[i].busy;
    end
  end

  rs_pick_ready #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_disp (
`ifdef RS_AGE_SELECT_EN
    .age_i   (age_q),
`endif
    .req_i   (ready_vec),
    .valid_o (disp_valid),
    .idx_o   (disp_idx)
  );

  // Equal stamps make the free-slot search fall back to lowest index.
  rs_pick_ready #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_free (
`ifdef RS_AGE_SELECT_EN
    .age_i   ('0),
`endif
    .req_i   (free_vec),
    .valid_o (free_valid),
    .idx_o   (free_idx)
  );

  assign issue_acc = bus.iss_valid_in && !full_q && free_valid;

  // Issue-time bypass: an operand being broadcast this cycle is captured on entry.
  assign byp_j = bus.cdb_valid_in && !bus.iss_qj_rdy_in && (bus.cdb_tag_in == bus.iss_qj_in);
  assign byp_k = bus.cdb_valid_in && !bus.iss_qk_rdy_in && (bus.cdb_tag_in == bus.iss_qk_in);

  always_comb begin
    new_ent        = '0;
    new_ent.busy   = 1'b1;
    new_ent.itype  = bus.iss_type_in;
    new_ent.vj     = byp_j ? bus.cdb_value_in : bus.iss_vj_in;
    new_ent.vk     = byp_k ? bus.cdb_value_in : bus.iss_vk_in;
    new_ent.qj     = bus.iss_qj_in;
    new_ent.qk     = bus.iss_qk_in;
    new_ent.qj_rdy = bus.iss_qj_rdy_in | byp_j;
    new_ent.qk_rdy = bus.iss_qk_rdy_in | byp_k;
    new_ent.a      = bus.iss_a_in;
    new_ent.pc     = bus.iss_pc_in;
    new_ent.dest   = bus.iss_dest_in;
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy && bus.cdb_valid_in) begin
        if (!ent_q[i].qj_rdy && ent_q[i].qj == bus.cdb_tag_in) begin
          ent_d[i].vj     = bus.cdb_value_in;
          ent_d[i].qj_rdy = 1'b1;
        end
        if (!ent_q[i].qk_rdy && ent_q[i].qk == bus.cdb_tag_in) begin
          ent_d[i].vk     = bus.cdb_value_in;
          ent_d[i].qk_rdy = 1'b1;
        end
      end
    end
    if (disp_valid) ent_d[disp_idx].busy = 1'b0;
    if (issue_acc)  ent_d[free_idx] = new_ent;

    count_d    = count_q + CNT_W'(issue_acc) - CNT_W'(disp_valid);
    full_d     = (count_d == CNT_W'(RS_SIZE));
    ex_valid_d = disp_valid;
    ex_d       = ex_q;
    if (disp_valid) begin
      ex_d.itype = ent_q[disp_idx].itype;
      ex_d.vj    = ent_q[disp_idx].vj;
      ex_d.vk    = ent_q[disp_idx].vk;
      ex_d.a     = ent_q[disp_idx].a;
      ex_d.pc    = ent_q[disp_idx].pc;
      ex_d.dest  = ent_q[disp_idx].dest;
    end
  end

`ifdef RS_AGE_SELECT_EN
  always_comb begin
    age_d     = age_q;
    age_cnt_d = age_cnt_q;
    if (issue_acc) begin
      age_d[free_idx] = age_cnt_q;
      age_cnt_d       = age_cnt_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
`ifdef RS_AGE_SELECT_EN
      age_q      <= '0;
      age_cnt_q  <= '0;
`endif
    end else if (rdy_in) begin
      if (clear_in) begin
        // Only busy matters after a flush; stale payloads are overwritten on reuse.
        for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= 1'b0;
        count_q    <= '0;
        full_q     <= 1'b0;
        ex_valid_q <= 1'b0;
`ifdef RS_AGE_SELECT_EN
        age_cnt_q  <= '0;
`endif
      end else begin
        for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
        count_q    <= count_d;
        full_q     <= full_d;
        ex_valid_q <= ex_valid_d;
        ex_q       <= ex_d;
`ifdef RS_AGE_SELECT_EN
        age_q      <= age_d;
        age_cnt_q  <= age_cnt_d;
`endif
      end
    end
  end

  assign bus.full_out     = full_q;
  assign bus.ex_valid_out = ex_valid_q;
  assign bus.ex_type_out  = ex_q.itype;
  assign bus.ex_vj_out    = ex_q.vj;
  assign bus.ex_vk_out    = ex_q.vk;
  assign bus.ex_a_out     = ex_q.a;
  assign bus.ex_pc_out    = ex_q.pc;
  assign bus.ex_dest_out  = ex_q.dest;

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - scoreboard bench for alu_reservation_station
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  logic clk = 1'b0;
  logic rst_n, rdy, clear;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_reservation_station_if bus();

  alu_reservation_station dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .clear_in (clear),
    .bus      (bus.slave)
  );

  typedef struct {
    logic [5:0]  t;
    logic [31:0] vj, vk, a, pc;
    logic [3:0]  dest;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t me;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu(input logic [5:0] t, input logic [31:0] vj, vk, a);
    case (t)
      ITYPE_ADD:  return vj + vk;
      ITYPE_SUB:  return vj - vk;
      ITYPE_ADDI: return vj + a;
      default:    return 32'h0;
    endcase
  endfunction

  // Monitor: every cycle with ex_valid_out is one dispatch to be matched against the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.ex_valid_out === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_dispatch: got dest %0d pc %0h expected no dispatch",
                 bus.ex_dest_out, bus.ex_pc_out);
      end else begin
        me = q.pop_front();
        chk("disp_cycle", 160'(cyc), 160'(me.cyc));
        chk("disp_fields",
            160'({bus.ex_type_out, bus.ex_vj_out, bus.ex_vk_out, bus.ex_a_out, bus.ex_pc_out, bus.ex_dest_out}),
            160'({me.t, me.vj, me.vk, me.a, me.pc, me.dest}));
        chk("exec_result", 160'(alu(bus.ex_type_out, bus.ex_vj_out, bus.ex_vk_out, bus.ex_a_out)),
            160'(me.res));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_iss(input logic [5:0] t, input logic [31:0] vj, vk, input logic qjr, qkr,
                         input logic [3:0] qj, qk, input logic [31:0] a, pc, input logic [3:0] dest);
    bus.iss_valid_in  = 1'b1;
    bus.iss_type_in   = t;
    bus.iss_vj_in     = vj;
    bus.iss_vk_in     = vk;
    bus.iss_qj_rdy_in = qjr;
    bus.iss_qk_rdy_in = qkr;
    bus.iss_qj_in     = qj;
    bus.iss_qk_in     = qk;
    bus.iss_a_in      = a;
    bus.iss_pc_in     = pc;
    bus.iss_dest_in   = dest;
  endtask

  task automatic push(input logic [5:0] t, input logic [31:0] vj, vk, a, pc, input logic [3:0] dest,
                      input logic [31:0] res, input int delay);
    exp_t e;
    e.t = t; e.vj = vj; e.vk = vk; e.a = a; e.pc = pc; e.dest = dest; e.res = res;
    e.cyc = cyc + delay;
    q.push_back(e);
  endtask

  task automatic cdb(input logic v, input logic [3:0] tag, input logic [31:0] val);
    bus.cdb_valid_in = v;
    bus.cdb_tag_in   = tag;
    bus.cdb_value_in = val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    rdy   = 1'b1;
    clear = 1'b0;
    cdb(1'b0, 4'd0, 32'd0);
    set_iss(ITYPE_ADDI, 32'd1, 32'd2, 1'b1, 1'b1, 4'd0, 4'd0, 32'd3, 32'd4, 4'd5);
    tick();
    tick();
    @(negedge clk);
    chk("reset_ex_valid", 160'(bus.ex_valid_out), 160'(0));
    chk("reset_full", 160'(bus.full_out), 160'(0));
    chk("reset_ex_data",
        160'({bus.ex_type_out, bus.ex_vj_out, bus.ex_vk_out, bus.ex_a_out, bus.ex_pc_out, bus.ex_dest_out}),
        160'(0));
    rst_n = 1'b1;
    bus.iss_valid_in = 1'b0;
    tick();

    // ADDI with both operands ready: dispatch two edges after issue is driven.
    set_iss(ITYPE_ADDI, 32'd5, 32'd0, 1'b1, 1'b1, 4'd0, 4'd0, 32'd7, 32'h100, 4'd3);
    push(ITYPE_ADDI, 32'd5, 32'd0, 32'd7, 32'h100, 4'd3, 32'd12, 2);
    tick();
    bus.iss_valid_in = 1'b0;
    repeat (3) tick();

    // Snoop wake-up of vj two cycles after issue.
    set_iss(ITYPE_ADD, 32'hdead, 32'd1, 1'b0, 1'b1, 4'd2, 4'd0, 32'd0, 32'h104, 4'd4);
    tick();
    bus.iss_valid_in = 1'b0;
    tick();
    cdb(1'b1, 4'd2, 32'h10);
    push(ITYPE_ADD, 32'h10, 32'd1, 32'd0, 32'h104, 4'd4, 32'h11, 2);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    repeat (3) tick();

    // Issue-time bypass of vk.
    set_iss(ITYPE_SUB, 32'd20, 32'hbeef, 1'b1, 1'b0, 4'd0, 4'd9, 32'd0, 32'h108, 4'd5);
    cdb(1'b1, 4'd9, 32'd4);
    push(ITYPE_SUB, 32'd20, 32'd4, 32'd0, 32'h108, 4'd5, 32'd16, 2);
    tick();
    bus.iss_valid_in = 1'b0;
    cdb(1'b0, 4'd0, 32'd0);
    repeat (3) tick();

    // rdy_in low freezes everything, including the pending issue.
    rdy = 1'b0;
    set_iss(ITYPE_ADD, 32'd3, 32'd4, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 32'h10c, 4'd6);
    repeat (3) tick();
    chk("frozen_full", 160'(bus.full_out), 160'(0));
    rdy = 1'b1;
    push(ITYPE_ADD, 32'd3, 32'd4, 32'd0, 32'h10c, 4'd6, 32'd7, 2);
    tick();
    bus.iss_valid_in = 1'b0;
    repeat (3) tick();

    // Fill all 8 entries waiting on tag 1.
    for (int i = 0; i < 8; i++) begin
      set_iss(ITYPE_ADD, 32'hbad0, 32'(i), 1'b0, 1'b1, 4'd1, 4'd0, 32'd0, 32'h200 + 32'(4 * i), 4'(i));
      tick();
      if (i == 6) chk("full_at_7", 160'(bus.full_out), 160'(0));
    end
    chk("full_at_8", 160'(bus.full_out), 160'(1));
    set_iss(ITYPE_ADD, 32'd0, 32'd9, 1'b0, 1'b1, 4'd1, 4'd0, 32'd0, 32'h300, 4'd15);
    tick();
    bus.iss_valid_in = 1'b0;
    chk("full_after_drop", 160'(bus.full_out), 160'(1));
    cdb(1'b1, 4'd1, 32'h40);
    for (int i = 0; i < 8; i++)
      push(ITYPE_ADD, 32'h40, 32'(i), 32'd0, 32'h200 + 32'(4 * i), 4'(i), 32'h40 + 32'(i), 2 + i);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    chk("full_during_snoop", 160'(bus.full_out), 160'(1));
    tick();
    chk("full_after_first_disp", 160'(bus.full_out), 160'(0));
    repeat (10) tick();

    // Flush with four waiting entries and one ready entry.
    for (int i = 0; i < 4; i++) begin
      set_iss(ITYPE_ADD, 32'd0, 32'(i), 1'b0, 1'b1, 4'd5, 4'd0, 32'd0, 32'h400 + 32'(4 * i), 4'(i + 8));
      tick();
    end
    set_iss(ITYPE_ADD, 32'd1, 32'd1, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 32'h410, 4'd12);
    tick();
    bus.iss_valid_in = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("flush_ex_valid", 160'(bus.ex_valid_out), 160'(0));
    chk("flush_full", 160'(bus.full_out), 160'(0));
    tick();
    cdb(1'b1, 4'd5, 32'h99);
    tick();
    cdb(1'b0, 4'd0, 32'd0);
    repeat (3) tick();
    set_iss(ITYPE_ADD, 32'd3, 32'd4, 1'b1, 1'b1, 4'd0, 4'd0, 32'd0, 32'h420, 4'd13);
    push(ITYPE_ADD, 32'd3, 32'd4, 32'd0, 32'h420, 4'd13, 32'd7, 2);
    tick();
    bus.iss_valid_in = 1'b0;
    repeat (4) tick();

    chk("queue_drained", 160'(q.size()), 160'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Tomasulo reservation station for ALU/branch/jump instructions; sits between decode/issue and the combinational execute unit.
- Buffers issued instructions and snoops the common data bus (CDB) for missing operands.
- Each cycle it dispatches one operand-ready entry to the execute unit through a registered output stage.
- Flushed on branch mispredict.

Parameters:
- RS_SIZE, 8, number of entries (power of 2, 2..16)
- TAG_W, 4, ROB tag width
- TYPE_W, 6, instruction-type code width (shared package value)
- XLEN, 32, data/address width

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  synchronous active-low reset
- rdy_in  in  1  global ready; low freezes all state
- clear_in  in  1  mispredict flush
- iss_valid_in  in  1  issue request
- iss_type_in  in  TYPE_W  instruction type
- iss_vj_in, iss_vk_in  in  XLEN  operand values
- iss_qj_rdy_in, iss_qk_rdy_in  in  1  operand value already valid
- iss_qj_in, iss_qk_in  in  TAG_W  producer ROB tags
- iss_a_in  in  XLEN  immediate
- iss_pc_in  in  XLEN  instruction pc
- iss_dest_in  in  TAG_W  destination ROB tag
- full_out  out  1  no free entry
- cdb_valid_in  in  1  broadcast valid
- cdb_tag_in  in  TAG_W  broadcast tag
- cdb_value_in  in  XLEN  broadcast value
- ex_valid_out  out  1  dispatch valid
- ex_type_out  out  TYPE_W  dispatched type
- ex_vj_out, ex_vk_out, ex_a_out, ex_pc_out  out  XLEN  dispatched fields
- ex_dest_out  out  TAG_W  dispatched destination tag

Behaviour:
- Reset (rst_n_in=0 at posedge): all entries invalid; count=0; full_out=0; ex_valid_out=0; all ex_* data outputs 0. Reset overrides rdy_in and clear_in.
- rdy_in=0: no state change. Issue ignored, no dispatch, CDB ignored, ex_* hold their values.
- Entry fields: busy, type, vj, vk, qj, qk, qj_rdy, qk_rdy, a, pc, dest. An entry is ready when busy && qj_rdy && qk_rdy.
- Issue:
  - When iss_valid_in && !full_out, write into the lowest-index free entry at the posedge.
  - If cdb_valid_in in the same cycle and cdb_tag_in matches a not-ready iss_qj/qk, capture cdb_value_in and set the ready flag immediately (issue-time bypass).
  - Issuing while full_out=1 is a protocol violation; the request is dropped and the bench asserts on it.
- Snoop: every busy entry with qX_rdy=0 and qX==cdb_tag_in captures cdb_value_in into vX and sets qX_rdy at the posedge.
- Dispatch:
  - Each cycle, select among entries ready at the start of the cycle; the lowest index wins by default.
  - At the posedge, copy the selected entry into the ex_* registers, set ex_valid_out=1 and free the entry.
  - If no entry is ready, ex_valid_out=0 and the ex_* data registers hold.
  - Minimum latency: an issue with both operands ready at edge t gives ex_valid_out=1 after edge t+1.
  - An operand captured via snoop at edge t makes the entry eligible at edge t+1; there is no same-cycle snoop-to-dispatch path.
- Counting and full:
  - count += issue accepted, count -= dispatch.
  - full_out is registered: full_out = (next count == RS_SIZE).
  - Simultaneous issue and dispatch at count=RS_SIZE-1 leaves count unchanged and full_out=0.
- Flush: clear_in=1 at posedge invalidates all entries, count=0, full_out=0, ex_valid_out=0. Issue and dispatch in that cycle are discarded.
- Tag rules:
  - Tag 0 is a legal ROB tag; readiness is carried by the qX_rdy flags only.
  - The CDB never broadcasts a tag that is not in flight.

Optional Feature:
- Macro: RS_AGE_SELECT_EN.
- With the macro defined:
  - Each entry carries a log2(RS_SIZE)+1-bit age stamp from a wrapping issue counter.
  - Dispatch selects the oldest ready entry, comparing wrap-aware via the MSB difference.
  - Ties are impossible.
  - The counter resets to 0 on reset and on clear_in.
- Without the macro: fixed lowest-index priority, and no age storage is synthesised.

Decomposition:
- Shared package (info include):
  - instruction-type codes, TYPE_W, XLEN, TAG_W
  - RS_SIZE default
  - an RS entry struct/field-width constants for reuse by the load/store buffer
- One sub-module, rs_pick_ready: a combinational priority selector taking the ready vector (and age stamps when RS_AGE_SELECT_EN is defined) and producing a valid flag plus the index. The same selector also finds the free slot when driven with the inverted busy vector.

Test Plan:
- Reset: hold rst_n_in=0 for 2 cycles with iss_valid_in=1 → ex_valid_out=0, full_out=0, all ex_* = 0; first issue after release lands in entry 0.
- Ready issue: ADDI with vj=5, a=7, dest=3, both rdy → ex_valid_out=1 exactly one cycle later with ex_vj_out=5, ex_a_out=7, ex_dest_out=3; execute unit returns 12.
- Snoop wake-up: issue ADD with qj=2 not ready and vk=1. Two cycles later apply cdb tag=2, value=0x10 → dispatch the following cycle with ex_vj_out=0x10, ex_vk_out=1.
- Issue-time bypass: issue SUB with qk=9 not ready while cdb tag=9, value=4 in the same cycle → dispatch next cycle with ex_vk_out=4.
- Full/back-pressure: issue 8 entries all waiting on tag 1 → full_out=1 after the 8th; a 9th issue is dropped. Broadcast tag 1 → dispatches from entries 0..7 in index order (oldest order with RS_AGE_SELECT_EN) over 8 cycles; full_out=0 after the first dispatch.
- Flush: with 5 busy entries and one ready, assert clear_in → next cycle ex_valid_out=0, full_out=0. A subsequent ready issue dispatches normally; no stale entry ever reappears.
